// File: rtl/multi_ch_ask_dds.sv
// -----------------------------------------------------------------------------
// multi_ch_ask_dds
//   Multi-channel DDS with on/off and reduced-amplitude ASK keying. One shared
//   phase accumulator drives NCH external sine ROMs (1-cycle read latency),
//   each with a static phase offset. The output mode only changes at an
//   accumulator wrap (unless turning on from, or off to, OFF). ASK bits are
//   pulled through a valid/ready handshake once every BIT_CYCLES samples.
//
// Ports
//   clk, rst_n            sample clock, asynchronous active-low reset
//   step_up/step_down     +1 / -1 frequency step pulses (saturating)
//   step_load, step_in    load strobe and value (clamped to [STEP_MIN,STEP_MAX])
//   mode_req              0=OFF 1=SINE 2=ASK 3=ASK_LOW
//   phase_ofs             per-channel phase offset, ROM_AW bits each
//   bit_data/valid/ready  ASK bit stream handshake
//   rom_addr, rom_data    external ROM address (registered) and read data
//   da_clk                inverted clk, DAC samples mid-cycle
//   da_data               per-channel DAC samples
//   cur_step, cur_mode    current step register and active mode
//   bit_active, underrun  current keying bit, one-cycle missing-bit pulse
//   phase_acc             channel-0 accumulator top 16 bits
// -----------------------------------------------------------------------------
module multi_ch_ask_dds #(
    parameter int NCH        = 2,
    parameter int ACC_W      = 24,
    parameter int STEP_W     = 20,
    parameter int ROM_AW     = 10,
    parameter int DAC_W      = 10,
    parameter int STEP_INIT  = 1000,
    parameter int STEP_MIN   = 1,
    parameter int STEP_MAX   = 9999,
    parameter int BIT_CYCLES = 2000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    step_up,
    input  logic                    step_down,
    input  logic                    step_load,
    input  logic [STEP_W-1:0]       step_in,
    input  logic [1:0]              mode_req,
    input  logic [NCH*ROM_AW-1:0]   phase_ofs,
    input  logic                    bit_data,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    output logic [NCH*ROM_AW-1:0]   rom_addr,
    input  logic [NCH*DAC_W-1:0]    rom_data,
    output logic                    da_clk,
    output logic [NCH*DAC_W-1:0]    da_data,
    output logic [STEP_W-1:0]       cur_step,
    output logic [1:0]              cur_mode,
    output logic                    bit_active,
    output logic                    underrun,
    output logic [15:0]             phase_acc
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SINE    = 2'd1,
        MODE_ASK     = 2'd2,
        MODE_ASK_LOW = 2'd3
    } mode_t;

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [STEP_W-1:0] L_STEP_INIT = STEP_W'(STEP_INIT);
    localparam logic [STEP_W-1:0] L_STEP_MIN  = STEP_W'(STEP_MIN);
    localparam logic [STEP_W-1:0] L_STEP_MAX  = STEP_W'(STEP_MAX);
    localparam logic [CNT_W-1:0]  L_BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [DAC_W-1:0]  L_MID       = {1'b1, {(DAC_W-1){1'b0}}};

    // State
    logic [STEP_W-1:0]       r_step;
    logic [ACC_W-1:0]        r_acc;
    mode_t                   r_mode;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic                    r_bit_active;
    logic                    r_underrun;
    logic [NCH*ROM_AW-1:0]   r_rom_addr;
    logic [NCH*DAC_W-1:0]    r_da;
    // Keying state travels alongside its sample through the ROM pipeline
    mode_t                   r_mode_d1, r_mode_d2;
    logic                    r_act_d1, r_act_d2;

    // Next-state
    logic [STEP_W-1:0]       w_step_nxt;
    logic [ACC_W:0]          w_acc_sum;
    logic                    w_wrap;
    mode_t                   w_mode_req;
    mode_t                   w_mode_nxt;
    logic                    w_cur_ask, w_nxt_ask;
    logic                    w_bit_ready;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_act_nxt;
    logic                    w_under_nxt;
    logic [NCH*ROM_AW-1:0]   w_addr_nxt;
    logic [NCH*DAC_W-1:0]    w_da_nxt;

    // Step register
    always_comb begin
        w_step_nxt = r_step;
        if (step_load) begin
            if (step_in < L_STEP_MIN)      w_step_nxt = L_STEP_MIN;
            else if (step_in > L_STEP_MAX) w_step_nxt = L_STEP_MAX;
            else                           w_step_nxt = step_in;
        end else if (step_up && !step_down) begin
            w_step_nxt = (r_step >= L_STEP_MAX) ? L_STEP_MAX : r_step + STEP_W'(1);
        end else if (step_down && !step_up) begin
            w_step_nxt = (r_step <= L_STEP_MIN) ? L_STEP_MIN : r_step - STEP_W'(1);
        end
    end

    // Accumulator carry-out marks the wrap on which mode changes take effect
    assign w_acc_sum  = {1'b0, r_acc} + (ACC_W+1)'(r_step);
    assign w_wrap     = w_acc_sum[ACC_W];
    assign w_mode_req = mode_t'(mode_req);

    // Mode / bit-timer next state
    always_comb begin
        w_mode_nxt  = r_mode;
        w_cnt_nxt   = '0;
        w_act_nxt   = r_bit_active;
        w_under_nxt = 1'b0;

        if (r_mode == MODE_OFF || w_mode_req == MODE_OFF || w_wrap)
            w_mode_nxt = w_mode_req;

        w_cur_ask   = (r_mode == MODE_ASK) || (r_mode == MODE_ASK_LOW);
        w_nxt_ask   = (w_mode_nxt == MODE_ASK) || (w_mode_nxt == MODE_ASK_LOW);
        w_bit_ready = w_cur_ask && (r_bit_cnt == L_BIT_LAST);

        if (w_nxt_ask) begin
            if (!w_cur_ask)       w_cnt_nxt = L_BIT_LAST;   // first ASK cycle requests a bit
            else if (w_bit_ready) w_cnt_nxt = '0;
            else                  w_cnt_nxt = r_bit_cnt + CNT_W'(1);
        end

        case (w_mode_nxt)
            MODE_OFF:  w_act_nxt = 1'b0;
            MODE_SINE: w_act_nxt = 1'b1;
            default: begin
                // ASK<->ASK_LOW keeps the current bit; only a bit slot changes it
                if (w_bit_ready) w_act_nxt = bit_valid & bit_data;
            end
        endcase

        w_under_nxt = w_bit_ready & ~bit_valid;
    end

    // Per-channel address generation and output shaping
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [DAC_W-1:0]        w_rd;
        logic [DAC_W-1:0]        w_low;
        logic [DAC_W-1:0]        w_sel;
        logic signed [DAC_W:0]   w_diff;

        assign w_addr_nxt[g*ROM_AW +: ROM_AW] =
            r_acc[ACC_W-1 -: ROM_AW] + phase_ofs[g*ROM_AW +: ROM_AW];

        assign w_rd   = rom_data[g*DAC_W +: DAC_W];
        assign w_diff = $signed({1'b0, w_rd}) - $signed({1'b0, L_MID});
        // Quarter-amplitude about midscale; the modular add cannot overflow
        assign w_low  = L_MID + DAC_W'(w_diff >>> 2);

        always_comb begin
            w_sel = L_MID;
            case (r_mode_d2)
                MODE_SINE:    w_sel = w_rd;
                MODE_ASK:     w_sel = r_act_d2 ? w_rd : L_MID;
                MODE_ASK_LOW: w_sel = r_act_d2 ? w_rd : w_low;
                default:      w_sel = L_MID;
            endcase
        end

        assign w_da_nxt[g*DAC_W +: DAC_W] = w_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step       <= L_STEP_INIT;
            r_acc        <= '0;
            r_mode       <= MODE_OFF;
            r_bit_cnt    <= '0;
            r_bit_active <= 1'b0;
            r_underrun   <= 1'b0;
            r_rom_addr   <= '0;
            r_da         <= {NCH{L_MID}};
            r_mode_d1    <= MODE_OFF;
            r_mode_d2    <= MODE_OFF;
            r_act_d1     <= 1'b0;
            r_act_d2     <= 1'b0;
        end else begin
            r_step       <= w_step_nxt;
            r_acc        <= w_acc_sum[ACC_W-1:0];
            r_mode       <= w_mode_nxt;
            r_bit_cnt    <= w_cnt_nxt;
            r_bit_active <= w_act_nxt;
            r_underrun   <= w_under_nxt;
            r_rom_addr   <= w_addr_nxt;
            r_da         <= w_da_nxt;
            r_mode_d1    <= r_mode;
            r_mode_d2    <= r_mode_d1;
            r_act_d1     <= r_bit_active;
            r_act_d2     <= r_act_d1;
        end
    end

    if (ACC_W >= 16) begin : g_pa_wide
        assign phase_acc = r_acc[ACC_W-1 -: 16];
    end else begin : g_pa_narrow
        assign phase_acc = {r_acc, {(16-ACC_W){1'b0}}};
    end

    assign da_clk     = ~clk;
    assign da_data    = r_da;
    assign rom_addr   = r_rom_addr;
    assign cur_step   = r_step;
    assign cur_mode   = r_mode;
    assign bit_active = r_bit_active;
    assign underrun   = r_underrun;
    assign bit_ready  = w_bit_ready;

endmodule
